// File: rtl/mem_interface.sv
// MAR/MDR memory interface stage in front of a synchronous RAM with one-clock
// read latency. Sequences single-cycle read/write strobes and reports
// completion to the control unit through a busy/done/addr_err handshake.
module mem_interface #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned MEM_DEPTH  = 512
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  MARin,
  input  logic                  MDRin,
  input  logic                  rd_req,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] RAMout,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] RAMin,
  output logic                  enableRead,
  output logic                  enableWrite,
  output logic [DATA_WIDTH-1:0] MDRout,
  output logic                  busy,
  output logic                  done,
  output logic                  addr_err
);

  localparam logic [DATA_WIDTH-1:0] DEPTH_LIMIT = DATA_WIDTH'(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] mar;
  logic [DATA_WIDTH-1:0] mar_next;
  logic [DATA_WIDTH-1:0] mdr;
  logic [DATA_WIDTH-1:0] mdr_next;
  logic                  out_of_range;

  // RAM-facing and bus-facing views of MAR/MDR
  assign address = mar[ADDR_WIDTH-1:0];
  assign RAMin   = mdr;
  assign MDRout  = mdr;

  // Next-state, register loads and the RD_WAIT capture
  always_comb begin
    state_next   = state;
    mar_next     = mar;
    mdr_next     = mdr;
    out_of_range = 1'b0;
    case (state)
      IDLE: begin
        if (MARin) mar_next = bus_in;
        if (MDRin) mdr_next = bus_in;
        out_of_range = (mar_next >= DEPTH_LIMIT);
        if (rd_req) begin
          state_next = out_of_range ? ERR : RD_ISSUE;
        end else if (wr_req) begin
          state_next = out_of_range ? ERR : WR_ISSUE;
        end
      end
      RD_ISSUE: state_next = RD_WAIT;
      RD_WAIT: begin
        mdr_next   = RAMout;
        state_next = DONE;
      end
      WR_ISSUE: state_next = DONE;
      DONE:     state_next = IDLE;
      ERR:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State, MAR/MDR and state-decoded outputs, registered so no input reaches an output
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      mar         <= '0;
      mdr         <= '0;
      enableRead  <= 1'b0;
      enableWrite <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      state       <= state_next;
      mar         <= mar_next;
      mdr         <= mdr_next;
      enableRead  <= (state_next == RD_ISSUE);
      enableWrite <= (state_next == WR_ISSUE);
      busy        <= (state_next != IDLE);
      done        <= (state_next == DONE) || (state_next == ERR);
      addr_err    <= (state_next == ERR);
    end
  end

endmodule

// File: tb/tb_mem_interface.sv
// Scoreboard bench for mem_interface with a behavioural 512x32 synchronous RAM.
module tb_mem_interface;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;

  logic          clock;
  logic          reset_n;
  logic [DW-1:0] bus_in;
  logic          MARin;
  logic          MDRin;
  logic          rd_req;
  logic          wr_req;
  logic [DW-1:0] RAMout;
  logic [AW-1:0] address;
  logic [DW-1:0] RAMin;
  logic          enableRead;
  logic          enableWrite;
  logic [DW-1:0] MDRout;
  logic          busy;
  logic          done;
  logic          addr_err;

  int vectors;
  int miscompares;
  int done_cnt;

  // expected completions {addr_err, MDR}, read strobes {address}, write strobes {address, data}
  logic [DW:0]      done_q[$];
  logic [AW-1:0]    rd_q[$];
  logic [AW+DW-1:0] wr_q[$];

  // RAM model with a preload port owned by the stimulus
  logic [DW-1:0] mem [0:511];
  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  mem_interface #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(512)) dut (
    .clock(clock), .reset_n(reset_n), .bus_in(bus_in), .MARin(MARin), .MDRin(MDRin),
    .rd_req(rd_req), .wr_req(wr_req), .RAMout(RAMout), .address(address), .RAMin(RAMin),
    .enableRead(enableRead), .enableWrite(enableWrite), .MDRout(MDRout), .busy(busy),
    .done(done), .addr_err(addr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    if (enableWrite) mem[address] <= RAMin;
    if (enableRead) RAMout <= mem[address];
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops expectations whenever the DUT strobes the RAM or signals done
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (enableRead === 1'b1 && enableWrite === 1'b1)
        check("strobe_overlap", 32'd1, 32'd0);
      if (enableRead === 1'b1) begin
        if (rd_q.size() == 0) check("unexpected_read", 32'd1, 32'd0);
        else check("read_addr", DW'(address), DW'(rd_q.pop_front()));
      end
      if (enableWrite === 1'b1) begin
        if (wr_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
        else begin
          logic [AW+DW-1:0] w;
          w = wr_q.pop_front();
          check("write_addr", DW'(address), DW'(w[AW+DW-1:DW]));
          check("write_data", RAMin, w[DW-1:0]);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        if (done_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          logic [DW:0] d;
          d = done_q.pop_front();
          check("done_addr_err", DW'(addr_err), DW'(d[DW]));
          check("done_mdr", MDRout, d[DW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_mar(input logic [DW-1:0] v);
    bus_in = v; MARin = 1'b1; tick(); MARin = 1'b0;
  endtask

  task automatic load_mdr(input logic [DW-1:0] v);
    bus_in = v; MDRin = 1'b1; tick(); MDRin = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d; tick(); pre_en = 1'b0;
  endtask

  // full read at current MAR with latency checks
  task automatic run_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd_q.push_back(a);
    done_q.push_back({1'b0, d});
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    check("rd_c1_enableRead", DW'(enableRead), 32'd1);
    tick();
    check("rd_c2_enableRead", DW'(enableRead), 32'd0);
    tick();
    check("rd_c3_done", DW'(done), 32'd1);
    check("rd_c3_mdr", MDRout, d);
    tick();
    check("rd_c4_busy", DW'(busy), 32'd0);
  endtask

  initial begin
    vectors = 0; miscompares = 0; done_cnt = 0;
    reset_n = 1'b0; bus_in = '0; MARin = 1'b0; MDRin = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    preload(9'h000, 32'h01000095);
    preload(9'h010, 32'hA5A5A5A5);
    tick();
    check("rst_address", DW'(address), 32'd0);
    check("rst_mdr", MDRout, 32'd0);
    check("rst_busy", DW'(busy), 32'd0);
    check("rst_done", DW'(done), 32'd0);
    check("rst_strobes", DW'({enableRead, enableWrite}), 32'd0);
    reset_n = 1'b1;

    // basic read of mem[0]
    load_mar(32'h0);
    run_read(9'h000, 32'h01000095);

    // write 0xDEADBEEF to 0x87, then read it back
    load_mdr(32'hDEADBEEF);
    load_mar(32'h87);
    wr_q.push_back({9'h087, 32'hDEADBEEF});
    done_q.push_back({1'b0, 32'hDEADBEEF});
    wr_req = 1'b1; tick(); wr_req = 1'b0;
    check("wr_c1_enableWrite", DW'(enableWrite), 32'd1);
    tick();
    check("wr_c2_done", DW'(done), 32'd1);
    tick();
    check("wr_mem87", mem[9'h087], 32'hDEADBEEF);
    run_read(9'h087, 32'hDEADBEEF);

    // out-of-range, MAR loaded in the same cycle as the request
    bus_in = 32'h00000200; MARin = 1'b1;
    done_q.push_back({1'b1, 32'hDEADBEEF});
    rd_req = 1'b1; tick(); rd_req = 1'b0; MARin = 1'b0;
    check("err_c1_done", DW'(done), 32'd1);
    check("err_c1_addr_err", DW'(addr_err), 32'd1);
    tick();
    check("err_c2_busy", DW'(busy), 32'd0);
    check("err_mdr_kept", MDRout, 32'hDEADBEEF);

    // bus activity during a read of 0x87 is ignored
    load_mar(32'h87);
    rd_q.push_back(9'h087);
    done_q.push_back({1'b0, 32'hDEADBEEF});
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    wr_req = 1'b1; MARin = 1'b1; bus_in = 32'd5; tick();
    wr_req = 1'b0; MARin = 1'b0; MDRin = 1'b1; bus_in = 32'h1234; tick();
    MDRin = 1'b0;
    check("busy_ign_done", DW'(done), 32'd1);
    check("busy_ign_mdr", MDRout, 32'hDEADBEEF);
    check("busy_ign_mar", DW'(address), 32'h087);
    tick();
    check("busy_ign_single_done", DW'(done), 32'd0);
    check("busy_ign_idle", DW'(busy), 32'd0);

    // simultaneous read and write: read wins
    load_mar(32'h10);
    load_mdr(32'h0BADF00D);
    rd_q.push_back(9'h010);
    done_q.push_back({1'b0, 32'hA5A5A5A5});
    rd_req = 1'b1; wr_req = 1'b1; tick(); rd_req = 1'b0; wr_req = 1'b0;
    check("both_c1_enableWrite", DW'(enableWrite), 32'd0);
    check("both_c1_enableRead", DW'(enableRead), 32'd1);
    tick(); tick();
    check("both_c3_mdr", MDRout, 32'hA5A5A5A5);
    tick();
    check("both_mem10", mem[9'h010], 32'hA5A5A5A5);

    // reset during RD_WAIT aborts the access without a done
    rd_q.push_back(9'h010);
    rd_req = 1'b1; tick(); rd_req = 1'b0;
    tick();
    reset_n = 1'b0; tick();
    check("abort_busy", DW'(busy), 32'd0);
    check("abort_done", DW'(done), 32'd0);
    check("abort_mdr", MDRout, 32'd0);
    check("abort_mar", DW'(address), 32'd0);
    check("abort_strobes", DW'({enableRead, enableWrite}), 32'd0);
    reset_n = 1'b1;
    run_read(9'h000, 32'h01000095);

    tick(); tick();
    check("sb_done_q_empty", DW'(done_q.size()), 32'd0);
    check("sb_rd_q_empty", DW'(rd_q.size()), 32'd0);
    check("sb_wr_q_empty", DW'(wr_q.size()), 32'd0);
    check("done_count", DW'(done_cnt), 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
